// File: rtl/dsp48a1_mac_ctrl.sv
// dsp48a1_mac_ctrl: sequences one DSP48A1 slice as a streaming signed
// dot-product engine. Operand pairs enter through a valid/ready handshake,
// are forwarded to the slice A/B ports, and the slice OPMODE is steered so
// the first product clears the accumulator and later ones add into P.
// Once the slice pipeline has drained, P is captured and returned through a
// second valid/ready handshake.
module dsp48a1_mac_ctrl #(
    parameter int LEN_W   = 16,
    parameter int DSP_LAT = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [17:0] in_a,
    input  logic signed [17:0] in_b,
    output logic [17:0]        dsp_A,
    output logic [17:0]        dsp_B,
    output logic [7:0]         dsp_OPMODE,
    output logic               dsp_CE,
    input  logic [47:0]        dsp_P,
    output logic [47:0]        result,
    output logic               result_valid,
    input  logic               result_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // OPMODE encodings: X=M/Z=0 starts a sum, X=M/Z=P accumulates,
    // X=0/Z=P holds P unchanged while no product is in flight.
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_HOLD  = 8'h08;

    localparam int             DW         = $clog2(DSP_LAT + 1);
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(DSP_LAT);

    state_t            state_r;
    state_t            state_s;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  len_s;
    logic [LEN_W-1:0]  count_r;
    logic [LEN_W-1:0]  count_s;
    logic              first_r;
    logic              first_s;
    logic [DW-1:0]     drain_cnt_r;
    logic [DW-1:0]     drain_cnt_s;
    logic [17:0]       dsp_a_r;
    logic [17:0]       dsp_a_s;
    logic [17:0]       dsp_b_r;
    logic [17:0]       dsp_b_s;
    logic [7:0]        opm_queue_r;
    logic [7:0]        opm_queue_s;
    logic [7:0]        opmode_r;
    logic              ce_r;
    logic              ce_s;
    logic              busy_r;
    logic              busy_s;
    logic [47:0]       result_r;
    logic [47:0]       result_s;
    logic              result_valid_r;
    logic              result_valid_s;

    assign in_ready     = (state_r == ST_RUN);
    assign busy         = busy_r;
    assign dsp_A        = dsp_a_r;
    assign dsp_B        = dsp_b_r;
    assign dsp_OPMODE   = opmode_r;
    assign dsp_CE       = ce_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;

    // Next-state and next-value logic for the job sequencer.
    always_comb begin
        state_s        = state_r;
        len_s          = len_r;
        count_s        = count_r;
        first_s        = first_r;
        drain_cnt_s    = drain_cnt_r;
        dsp_a_s        = 18'd0;
        dsp_b_s        = 18'd0;
        opm_queue_s    = OPM_HOLD;
        result_s       = result_r;
        result_valid_s = result_valid_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len != {LEN_W{1'b0}}) begin
                        len_s   = len;
                        count_s = {LEN_W{1'b0}};
                        first_s = 1'b1;
                        state_s = ST_RUN;
                    end else begin
                        // Empty job: answer immediately, slice stays frozen.
                        result_s       = 48'd0;
                        result_valid_s = 1'b1;
                        state_s        = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (in_valid) begin
                    dsp_a_s     = in_a;
                    dsp_b_s     = in_b;
                    opm_queue_s = first_r ? OPM_FIRST : OPM_ACC;
                    first_s     = 1'b0;
                    count_s     = count_r + LEN_W'(1);
                    if (count_s == len_r) begin
                        drain_cnt_s = {DW{1'b0}};
                        state_s     = ST_DRAIN;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    // Bubble: zero operands and hold P.
                    opm_queue_s = OPM_HOLD;
                end
            end

            ST_DRAIN: begin
                opm_queue_s = OPM_HOLD;
                if (drain_cnt_r == DRAIN_LAST) begin
                    result_s       = dsp_P;
                    result_valid_s = 1'b1;
                    state_s        = ST_DONE;
                end else begin
                    drain_cnt_s = drain_cnt_r + DW'(1);
                end
            end

            ST_DONE: begin
                if (result_ready) begin
                    result_valid_s = 1'b0;
                    state_s        = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        ce_s   = (state_s == ST_RUN) || (state_s == ST_DRAIN);
        busy_s = (state_s != ST_IDLE);
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Job bookkeeping, slice drive registers and result registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            len_r          <= {LEN_W{1'b0}};
            count_r        <= {LEN_W{1'b0}};
            first_r        <= 1'b0;
            drain_cnt_r    <= {DW{1'b0}};
            dsp_a_r        <= 18'd0;
            dsp_b_r        <= 18'd0;
            opm_queue_r    <= 8'h00;
            opmode_r       <= 8'h00;
            ce_r           <= 1'b0;
            busy_r         <= 1'b0;
            result_r       <= 48'd0;
            result_valid_r <= 1'b0;
        end else begin
            len_r          <= len_s;
            count_r        <= count_s;
            first_r        <= first_s;
            drain_cnt_r    <= drain_cnt_s;
            dsp_a_r        <= dsp_a_s;
            dsp_b_r        <= dsp_b_s;
            opm_queue_r    <= opm_queue_s;
            // OPMODE trails A/B by one cycle to line up with the slice's
            // extra A1/B1 -> M stage ahead of the post-adder.
            opmode_r       <= opm_queue_r;
            ce_r           <= ce_s;
            busy_r         <= busy_s;
            result_r       <= result_s;
            result_valid_r <= result_valid_s;
        end
    end

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// tb_dsp48a1_mac_ctrl: scoreboard bench with a small behavioural model of
// the DSP48A1 slice (A1/B1 -> M -> P, registered OPMODE, shared CE).
module tb_dsp48a1_mac_ctrl;

    localparam int LEN_W = 16;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               start = 1'b0;
    logic [LEN_W-1:0]   len = '0;
    logic               busy;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [17:0] in_a = '0;
    logic signed [17:0] in_b = '0;
    logic [17:0]        dsp_A;
    logic [17:0]        dsp_B;
    logic [7:0]         dsp_OPMODE;
    logic               dsp_CE;
    logic [47:0]        dsp_P;
    logic [47:0]        result;
    logic               result_valid;
    logic               result_ready = 1'b0;

    dsp48a1_mac_ctrl #(.LEN_W(LEN_W), .DSP_LAT(4)) dut (
        .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE), .dsp_CE(dsp_CE),
        .dsp_P(dsp_P), .result(result), .result_valid(result_valid),
        .result_ready(result_ready)
    );

    always #5 CLK = ~CLK;

    // Slice model (not reset by the controller's RST).
    logic signed [17:0] a1_m = '0;
    logic signed [17:0] b1_m = '0;
    logic signed [35:0] m_m = '0;
    logic [7:0]         opm_m = '0;
    logic [47:0]        p_m = '0;
    logic [47:0]        x_m;
    logic [47:0]        z_m;

    always_comb begin
        x_m = (opm_m[1:0] == 2'b01) ? {{12{m_m[35]}}, m_m} : 48'd0;
        z_m = (opm_m[3:2] == 2'b10) ? p_m : 48'd0;
    end

    always @(posedge CLK) begin
        if (dsp_CE) begin
            a1_m  <= dsp_A;
            b1_m  <= dsp_B;
            m_m   <= a1_m * b1_m;
            opm_m <= dsp_OPMODE;
            p_m   <= x_m + z_m;
        end
    end

    assign dsp_P = p_m;

    int          checks = 0;
    int          errors = 0;
    logic [47:0] exp_q[$];
    int          pa[8];
    int          pb[8];
    bit          first_exp = 1'b1;
    bit          ce_seen = 1'b0;
    bit          ab_v = 1'b0;
    logic [17:0] a_exp = '0;
    logic [17:0] b_exp = '0;
    bit          om_v[2] = '{1'b0, 1'b0};
    logic [7:0]  om_exp[2] = '{8'h00, 8'h00};

    task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and retire pending A/B/OPMODE checks.
    task automatic tick();
        @(negedge CLK);
        ce_seen = ce_seen | dsp_CE;
        if (ab_v) begin
            check_val("dsp_A", 48'(dsp_A), 48'(a_exp));
            check_val("dsp_B", 48'(dsp_B), 48'(b_exp));
        end
        ab_v = 1'b0;
        if (om_v[1]) check_val("dsp_OPMODE", 48'(dsp_OPMODE), 48'(om_exp[1]));
        om_v[1]   = om_v[0];
        om_exp[1] = om_exp[0];
        om_v[0]   = 1'b0;
    endtask

    task automatic drive(input bit v, input int a, input int b);
        in_valid = v;
        in_a     = 18'(a);
        in_b     = 18'(b);
        if (in_ready) begin
            ab_v      = 1'b1;
            a_exp     = v ? 18'(a) : 18'd0;
            b_exp     = v ? 18'(b) : 18'd0;
            om_v[0]   = 1'b1;
            om_exp[0] = v ? (first_exp ? 8'h01 : 8'h09) : 8'h08;
            if (v) first_exp = 1'b0;
        end
    endtask

    task automatic run_job(input int n, input int gap_after, input int gaps, input bit hold);
        longint      sum = 0;
        int          t = 0;
        logic [47:0] res_exp;
        for (int i = 0; i < n; i++) sum += longint'(pa[i]) * longint'(pb[i]);
        exp_q.push_back(48'(sum));
        ce_seen      = 1'b0;
        first_exp    = 1'b1;
        result_ready = !hold;
        start        = 1'b1;
        len          = LEN_W'(n);
        tick();
        start = 1'b0;
        check_val("busy_start", 48'(busy), 48'd1);
        for (int i = 0; i < n; i++) begin
            if (i == gap_after) begin
                for (int g = 0; g < gaps; g++) begin
                    drive(1'b0, 123, -45);
                    tick();
                end
            end
            check_val("in_ready_run", 48'(in_ready), 48'd1);
            drive(1'b1, pa[i], pb[i]);
            tick();
        end
        drive(1'b0, 0, 0);
        while (!result_valid && t < 20) begin
            tick();
            t++;
        end
        check_val("latency", 48'(t), (n > 0) ? 48'd5 : 48'd0);
        res_exp = exp_q.pop_front();
        check_val("result", result, res_exp);
        check_val("result_valid", 48'(result_valid), 48'd1);
        check_val("in_ready_done", 48'(in_ready), 48'd0);
        if (hold) begin
            for (int h = 0; h < 5; h++) begin
                start = (h % 2 == 0);
                len   = 16'd2;
                tick();
                check_val("hold_result", result, res_exp);
                check_val("hold_valid", 48'(result_valid), 48'd1);
                check_val("hold_busy", 48'(busy), 48'd1);
            end
            start        = 1'b0;
            result_ready = 1'b1;
        end
        tick();
        check_val("valid_cleared", 48'(result_valid), 48'd0);
        check_val("busy_idle", 48'(busy), 48'd0);
        if (n == 0) check_val("ce_len0", 48'(ce_seen), 48'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick();
        check_val("rst_busy", 48'(busy), 48'd0);
        check_val("rst_in_ready", 48'(in_ready), 48'd0);
        check_val("rst_dsp_A", 48'(dsp_A), 48'd0);
        check_val("rst_dsp_OPMODE", 48'(dsp_OPMODE), 48'd0);
        check_val("rst_dsp_CE", 48'(dsp_CE), 48'd0);
        check_val("rst_result_valid", 48'(result_valid), 48'd0);
        RST = 1'b0;
        tick();

        pa = '{2, 4, -1, 0, 0, 0, 0, 0};
        pb = '{3, 5, 7, 0, 0, 0, 0, 0};
        run_job(3, -1, 0, 1'b0);
        run_job(3, 1, 2, 1'b0);
        run_job(0, -1, 0, 1'b0);

        pa = '{100, 0, 0, 0, 0, 0, 0, 0};
        pb = '{100, 0, 0, 0, 0, 0, 0, 0};
        run_job(1, -1, 0, 1'b0);
        pa = '{-3, 1, 0, 0, 0, 0, 0, 0};
        pb = '{-3, -1, 0, 0, 0, 0, 0, 0};
        run_job(2, -1, 0, 1'b0);

        pa = '{-300, 7, 0, 0, 0, 0, 0, 0};
        pb = '{200, -8, 0, 0, 0, 0, 0, 0};
        run_job(2, -1, 0, 1'b1);

        pa = '{-131072, -131072, 0, 0, 0, 0, 0, 0};
        pb = '{-131072, 131071, 0, 0, 0, 0, 0, 0};
        run_job(2, -1, 0, 1'b0);

        // Reset in the middle of a four-pair job.
        pa = '{10, 20, 30, 40, 0, 0, 0, 0};
        pb = '{11, 21, 31, 41, 0, 0, 0, 0};
        first_exp = 1'b1;
        start     = 1'b1;
        len       = 16'd4;
        tick();
        start = 1'b0;
        drive(1'b1, pa[0], pb[0]);
        tick();
        drive(1'b1, pa[1], pb[1]);
        tick();
        drive(1'b0, 0, 0);
        #2;
        RST = 1'b1;
        #1;
        check_val("mid_rst_busy", 48'(busy), 48'd0);
        check_val("mid_rst_in_ready", 48'(in_ready), 48'd0);
        check_val("mid_rst_dsp_A", 48'(dsp_A), 48'd0);
        check_val("mid_rst_dsp_B", 48'(dsp_B), 48'd0);
        check_val("mid_rst_dsp_OPMODE", 48'(dsp_OPMODE), 48'd0);
        check_val("mid_rst_dsp_CE", 48'(dsp_CE), 48'd0);
        check_val("mid_rst_result", result, 48'd0);
        check_val("mid_rst_result_valid", 48'(result_valid), 48'd0);
        om_v[0] = 1'b0;
        om_v[1] = 1'b0;
        ab_v    = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        check_val("post_rst_busy", 48'(busy), 48'd0);
        pa = '{5, 0, 0, 0, 0, 0, 0, 0};
        pb = '{6, 0, 0, 0, 0, 0, 0, 0};
        run_job(1, -1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
